ram_arbiter: RTL

Shares one single-port, 1-cycle-latency RAM bank (264-bit × 2048) among `N_REQ` requesters, such as the weight loader, activation writer and result reader. Each cycle it picks at most one request using a valid/ready handshake and drives the RAM port from registers. It tags each read and returns the RAM data to the requester that issued it. It sits between the transformer datapath engines and each RAM instance.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_arbiter_rr_arbiter.sv | 90 +++++++++
 rtl/ram_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Default geometry and id-width constants for ram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int DEF_VEC_WIDTH  = 264;
  localparam int DEF_ARR_DEPTH  = 2048;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_ARR_DEPTH);
  localparam int ID_W           = $clog2(DEF_N_REQ);

  // Requester-id width for an arbitrary requester count (at least one bit).
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : One-hot grant generator. RAM_ARB_ROUND_ROBIN_EN selects
//               round-robin with a rotating pointer; otherwise fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_adv,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_id
);

`ifdef RAM_ARB_ROUND_ROBIN_EN

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  // Search starts at the pointer and wraps modulo N_REQ.
  always_comb begin
    logic          found;
    logic [ID_W:0] sum;
    logic [ID_W-1:0] idx;
    o_gnt    = '0;
    o_gnt_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        o_gnt_id   = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_adv) begin
      ptr_d = (o_gnt_id == ID_W'(N_REQ-1)) ? '0 : o_gnt_id + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`else

  logic unused_ok;
  assign unused_ok = ^{i_clk, i_rst, i_adv};

  always_comb begin
    logic found;
    o_gnt    = '0;
    o_gnt_id = '0;
    found    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && i_req[k]) begin
        o_gnt[k] = 1'b1;
        o_gnt_id = ID_W'(k);
        found    = 1'b1;
      end
    end
  end

`endif

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one 1-cycle-latency single-port RAM among N_REQ
//               requesters; tags reads and routes data back to the issuer.
//               Build option: RAM_ARB_ROUND_ROBIN_EN (round-robin grants).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int VEC_WIDTH  = DEF_VEC_WIDTH,
  parameter int ARR_DEPTH  = DEF_ARR_DEPTH,
  parameter int ADDR_WIDTH = $clog2(ARR_DEPTH),
  parameter int N_REQ      = DEF_N_REQ
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0]            i_req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [N_REQ*VEC_WIDTH-1:0]  i_req_wdata,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [N_REQ-1:0]            o_rsp_valid,
  output logic [VEC_WIDTH-1:0]        o_rsp_data,
  output logic                        o_ram_we,
  output logic [ADDR_WIDTH-1:0]       o_ram_addr,
  output logic [VEC_WIDTH-1:0]        o_ram_wdata,
  input  logic [VEC_WIDTH-1:0]        i_ram_rdata,
  output logic                        o_busy
);

  localparam int IDW = id_width(N_REQ);

  logic [N_REQ-1:0]      req_live;
  logic [N_REQ-1:0]      gnt;
  logic [IDW-1:0]        gnt_id;
  logic                  accept;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [VEC_WIDTH-1:0]  sel_wdata;

  logic                  ram_we_q,    ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic [VEC_WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
  logic                  cmd_rd_q,    cmd_rd_d;
  logic [IDW-1:0]        cmd_id_q,    cmd_id_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;

  // Nothing may be accepted while reset is held.
  assign req_live = i_rst ? '0 : i_req_valid;
  assign accept   = |gnt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (IDW)
  ) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (req_live),
    .i_adv    (accept),
    .o_gnt    (gnt),
    .o_gnt_id (gnt_id)
  );

  // One-hot grant makes an OR-reduction mux sufficient.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_we    = sel_we    | i_req_we[k];
        sel_addr  = sel_addr  | i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = sel_wdata | i_req_wdata[k*VEC_WIDTH +: VEC_WIDTH];
      end
    end
  end

  always_comb begin
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cmd_rd_d    = 1'b0;
    cmd_id_d    = cmd_id_q;
    if (accept) begin
      ram_we_d    = sel_we;
      ram_addr_d  = sel_addr;
      ram_wdata_d = sel_wdata;
      cmd_rd_d    = ~sel_we;
      cmd_id_d    = gnt_id;
    end
    rsp_valid_d = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rsp_valid_d[k] = cmd_rd_q && (cmd_id_q == IDW'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cmd_rd_q    <= 1'b0;
      cmd_id_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_id_q    <= cmd_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_req_ready = gnt;
  assign o_ram_we    = ram_we_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = i_ram_rdata;
  assign o_busy      = cmd_rd_q | ram_we_q | (|rsp_valid_q);

endmodule

`default_nettype wire
